// File: rtl/cronometro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cronometro_pkg
// Description : Shared types and constants for the stopwatch display block:
//               converter FSM state encoding, digit index and BCD types,
//               special segment codes and the double-dabble step function.
// Revision    : 1.0 - initial release
// ============================================================================
package cronometro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal code stored in the digit register to request a dash
    localparam bcd_t BCD_DASH = 4'hA;

    localparam int         SHIFT_STEPS = 7;
    localparam logic [6:0] CENT_MAX    = 7'd99;
    localparam logic [5:0] SEC_MAX     = 6'd59;

    // One double-dabble iteration on {tens, units, binary[6:0]}.
    // Any hundreds carry is dropped; values that would need it are dashed.
    function automatic logic [14:0] dd_step(input logic [14:0] w);
        logic [3:0]  tens;
        logic [3:0]  units;
        logic [14:0] adj;
        tens  = w[14:11];
        units = w[10:7];
        if (units >= 4'd5) units = units + 4'd3;
        if (tens  >= 4'd5) tens  = tens  + 4'd3;
        adj = {tens, units, w[6:0]};
        return adj << 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to active-low 7-segment decoder.
//               0-9 decode to digits, BCD_DASH to a dash, anything else blank.
// Ports       : bcd_i   - 4-bit BCD digit (or BCD_DASH)
//               seg_n_o - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import cronometro_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (bcd_i)
            4'd0:     seg_n_o = 7'b1000000;
            4'd1:     seg_n_o = 7'b1111001;
            4'd2:     seg_n_o = 7'b0100100;
            4'd3:     seg_n_o = 7'b0110000;
            4'd4:     seg_n_o = 7'b0011001;
            4'd5:     seg_n_o = 7'b0010010;
            4'd6:     seg_n_o = 7'b0000010;
            4'd7:     seg_n_o = 7'b1111000;
            4'd8:     seg_n_o = 7'b0000000;
            4'd9:     seg_n_o = 7'b0010000;
            BCD_DASH: seg_n_o = SEG_DASH;
            default:  seg_n_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cronometro_display.sv
`default_nettype none
// ============================================================================
// Module      : cronometro_display
// Description : Converts the stopwatch hundredths/seconds counts to BCD with a
//               fixed 9-cycle IDLE/SHIFT/COMMIT double-dabble converter and
//               multiplexes the four digits onto a common-anode display.
// Ports       : clk      - clock, rising edge
//               reset    - synchronous active-high reset
//               cent_seg - binary hundredths (0-99 nominal)
//               seg      - binary seconds (0-59 nominal)
//               seg_n    - registered segments {g,f,e,d,c,b,a}, active-low
//               an_n     - registered digit enables, active-low one-hot
//               dp_n     - registered decimal point, active-low
//               upd      - one-cycle pulse as new digits become visible
// Revision    : 1.0 - initial release
// ============================================================================
module cronometro_display
    import cronometro_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] cent_seg,
    input  logic [5:0] seg,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n,
    output logic       upd
);

    localparam int             CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    conv_state_e state_q, state_d;
    logic [2:0]  sh_cnt_q, sh_cnt_d;
    logic [14:0] cent_w_q, cent_w_d;
    logic [14:0] sec_w_q, sec_w_d;
    logic        cent_ovf_q, cent_ovf_d;
    logic        sec_ovf_q, sec_ovf_d;
    bcd_t        digit_q [4];
    bcd_t        digit_d [4];
    logic        upd_q, upd_d;

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        cent_w_d   = cent_w_q;
        sec_w_d    = sec_w_q;
        cent_ovf_d = cent_ovf_q;
        sec_ovf_d  = sec_ovf_q;
        digit_d    = digit_q;
        upd_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Overflow is judged on the latched binary value, so the
                // dash decision is independent of the BCD arithmetic.
                cent_w_d   = {8'd0, cent_seg};
                sec_w_d    = {9'd0, seg};
                cent_ovf_d = (cent_seg > CENT_MAX);
                sec_ovf_d  = (seg > SEC_MAX);
                sh_cnt_d   = 3'd0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                cent_w_d = dd_step(cent_w_q);
                sec_w_d  = dd_step(sec_w_q);
                sh_cnt_d = sh_cnt_q + 3'd1;
                if (sh_cnt_q == 3'(SHIFT_STEPS - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                digit_d[0] = cent_ovf_q ? BCD_DASH : cent_w_q[10:7];
                digit_d[1] = cent_ovf_q ? BCD_DASH : cent_w_q[14:11];
                digit_d[2] = sec_ovf_q  ? BCD_DASH : sec_w_q[10:7];
                digit_d[3] = sec_ovf_q  ? BCD_DASH : sec_w_q[14:11];
                // Registered alongside the digits so the pulse coincides
                // with the first cycle the new digits are held.
                upd_d      = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sh_cnt_q   <= 3'd0;
            cent_w_q   <= 15'd0;
            sec_w_q    <= 15'd0;
            cent_ovf_q <= 1'b0;
            sec_ovf_q  <= 1'b0;
            digit_q    <= '{default: 4'd0};
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            cent_w_q   <= cent_w_d;
            sec_w_q    <= sec_w_d;
            cent_ovf_q <= cent_ovf_d;
            sec_ovf_q  <= sec_ovf_d;
            digit_q    <= digit_d;
            upd_q      <= upd_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [6:0] dec_seg_n;
    logic [6:0] seg_n_d;
    logic [6:0] seg_n_q;
    logic [3:0] an_n_q;
    logic       dp_n_q;

    bcd_to_7seg u_dec (
        .bcd_i   (digit_q[idx_q]),
        .seg_n_o (dec_seg_n)
    );

    always_comb begin
        seg_n_d = dec_seg_n;
        if (LZ_BLANK && (idx_q == 2'd3) && (digit_q[3] == 4'd0)) begin
            seg_n_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_n_q  <= 4'b1111;
            seg_n_q <= SEG_BLANK;
            dp_n_q  <= 1'b1;
        end else begin
            an_n_q  <= ~(4'b0001 << idx_q);
            seg_n_q <= seg_n_d;
            dp_n_q  <= (idx_q != 2'd2);
        end
    end

    assign seg_n = seg_n_q;
    assign an_n  = an_n_q;
    assign dp_n  = dp_n_q;
    assign upd   = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_cronometro_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_cronometro_display
// Description : Directed self-checking bench for cronometro_display with
//               SCAN_DIV=4; one instance with LZ_BLANK=0 and one with 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cronometro_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] cent_seg = 7'd0;
    logic [5:0] seg = 6'd0;

    logic [6:0] seg_n, seg_n_lz;
    logic [3:0] an_n, an_n_lz;
    logic       dp_n, dp_n_lz;
    logic       upd, upd_lz;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cronometro_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .reset(reset), .cent_seg(cent_seg), .seg(seg),
        .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n), .upd(upd)
    );

    cronometro_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .reset(reset), .cent_seg(cent_seg), .seg(seg),
        .seg_n(seg_n_lz), .an_n(an_n_lz), .dp_n(dp_n_lz), .upd(upd_lz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the next upd pulse; ok=0 on timeout.
    task automatic wait_upd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (upd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits (bounded) until the given anode pattern is displayed.
    task automatic find_digit(input logic [3:0] pat, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (an_n === pat) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int idx_of(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic test_reset();
        int first;
        reset = 1'b1; cent_seg = 7'd0; seg = 6'd0;
        repeat (3) tick();
        n_checks++; if (an_n !== 4'b1111) $display("FAIL rst_an: got %b want 1111", an_n); else n_pass++;
        n_checks++; if (seg_n !== SB) $display("FAIL rst_seg: got %b want %b", seg_n, SB); else n_pass++;
        n_checks++; if (dp_n !== 1'b1) $display("FAIL rst_dp: got %b want 1", dp_n); else n_pass++;
        n_checks++; if (upd !== 1'b0) $display("FAIL rst_upd: got %b want 0", upd); else n_pass++;
        reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 1) begin
                n_checks++; if (an_n !== 4'b1110) $display("FAIL rel_an: got %b want 1110", an_n); else n_pass++;
                n_checks++; if (seg_n !== S0) $display("FAIL rel_seg: got %b want %b", seg_n, S0); else n_pass++;
                n_checks++; if (dp_n !== 1'b1) $display("FAIL rel_dp: got %b want 1", dp_n); else n_pass++;
            end
            if (e == 4) begin
                n_checks++; if (an_n !== 4'b1110) $display("FAIL scan_hold_an: got %b want 1110", an_n); else n_pass++;
            end
            if (e == 5) begin
                n_checks++; if (an_n !== 4'b1101) $display("FAIL scan_step_an: got %b want 1101", an_n); else n_pass++;
            end
            if (upd === 1'b1 && first == 0) first = e;
        end
        n_checks++; if (first !== 9) $display("FAIL first_upd_cycle: got %0d want 9", first); else n_pass++;
    endtask

    task automatic test_digits();
        bit ok;
        bit found;
        logic [3:0] pats  [4];
        logic [6:0] exp_s [4];
        logic       exp_d [4];
        pats  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_s = '{S9, S5, S5, S3};
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1};
        cent_seg = 7'd59; seg = 6'd35;
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL digits_upd1: got timeout want pulse"); else n_pass++;
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL digits_upd2: got timeout want pulse"); else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) begin
            find_digit(pats[k], found);
            n_checks++; if (found !== 1'b1) $display("FAIL digits_find%0d: got an_n %b want %b", k, an_n, pats[k]); else n_pass++;
            n_checks++; if (seg_n !== exp_s[k]) $display("FAIL digits_seg%0d: got %b want %b", k, seg_n, exp_s[k]); else n_pass++;
            n_checks++; if (dp_n !== exp_d[k]) $display("FAIL digits_dp%0d: got %b want %b", k, dp_n, exp_d[k]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        bit ok1;
        bit ok2;
        bit found;
        int         cents [4];
        int         secs  [4];
        logic [6:0] exps  [4][4];
        logic [3:0] pats  [4];
        cents = '{100, 3, 99, 127};
        secs  = '{7, 60, 59, 63};
        exps  = '{'{SD, SD, S7, S0}, '{S3, S0, SD, SD}, '{S9, S9, S9, S5}, '{SD, SD, SD, SD}};
        pats  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int v = 0; v < 4; v++) begin
            cent_seg = 7'(cents[v]); seg = 6'(secs[v]);
            wait_upd(ok1);
            wait_upd(ok2);
            n_checks++; if ((ok1 & ok2) !== 1'b1) $display("FAIL ovf_upd%0d: got timeout want pulses", v); else n_pass++;
            tick();
            for (int k = 0; k < 4; k++) begin
                find_digit(pats[k], found);
                n_checks++; if (found !== 1'b1 || seg_n !== exps[v][k])
                    $display("FAIL ovf_v%0d_d%0d: got an_n %b seg %b want an_n %b seg %b", v, k, an_n, seg_n, pats[k], exps[v][k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_midchange();
        bit ok;
        int i;
        logic [6:0] old_e [4];
        logic [6:0] new_e [4];
        logic [6:0] want;
        old_e = '{S2, S1, S4, S3};
        new_e = '{S7, S8, S1, S2};
        cent_seg = 7'd12; seg = 6'd34;
        wait_upd(ok);
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL mid_sync: got timeout want pulse"); else n_pass++;
        // upd cycle is the IDLE cycle; three ticks land in SHIFT cycle 3
        repeat (3) tick();
        cent_seg = 7'd87; seg = 6'd21;
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL mid_upd_old: got timeout want pulse"); else n_pass++;
        tick();
        for (int j = 0; j < 8; j++) begin
            i = idx_of(an_n);
            want = (i >= 0) ? old_e[i] : 7'bx;
            n_checks++; if (seg_n !== want) $display("FAIL mid_old_c%0d: got an_n %b seg %b want %b", j, an_n, seg_n, want); else n_pass++;
            tick();
        end
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL mid_upd_new: got timeout want pulse"); else n_pass++;
        tick();
        for (int j = 0; j < 8; j++) begin
            i = idx_of(an_n);
            want = (i >= 0) ? new_e[i] : 7'bx;
            n_checks++; if (seg_n !== want) $display("FAIL mid_new_c%0d: got an_n %b seg %b want %b", j, an_n, seg_n, want); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int first;
        cent_seg = 7'd59; seg = 6'd35;
        wait_upd(ok);
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rmid_sync: got timeout want pulse"); else n_pass++;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (an_n !== 4'b1111) $display("FAIL rmid_an: got %b want 1111", an_n); else n_pass++;
        n_checks++; if (upd !== 1'b0) $display("FAIL rmid_upd: got %b want 0", upd); else n_pass++;
        reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e <= 9) begin
                n_checks++; if (seg_n !== S0) $display("FAIL rmid_zero_e%0d: got %b want %b", e, seg_n, S0); else n_pass++;
            end
            if (upd === 1'b1 && first == 0) first = e;
        end
        n_checks++; if (first !== 9) $display("FAIL rmid_next_upd: got %0d want 9", first); else n_pass++;
    endtask

    task automatic test_lz_blank();
        bit ok;
        bit found;
        cent_seg = 7'd42; seg = 6'd5;
        wait_upd(ok);
        wait_upd(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL lz_upd: got timeout want pulse"); else n_pass++;
        tick();
        find_digit(4'b0111, found);
        n_checks++; if (found !== 1'b1) $display("FAIL lz_find3: got an_n %b want 0111", an_n); else n_pass++;
        n_checks++; if (an_n_lz !== 4'b0111) $display("FAIL lz_an: got %b want 0111", an_n_lz); else n_pass++;
        n_checks++; if (seg_n_lz !== SB) $display("FAIL lz_blank: got %b want %b", seg_n_lz, SB); else n_pass++;
        n_checks++; if (seg_n !== S0) $display("FAIL nolz_zero: got %b want %b", seg_n, S0); else n_pass++;
        find_digit(4'b1011, found);
        n_checks++; if (found !== 1'b1 || seg_n_lz !== S5) $display("FAIL lz_units: got an_n %b seg %b want 1011 %b", an_n, seg_n_lz, S5); else n_pass++;
        seg = 6'd35;
        wait_upd(ok);
        wait_upd(ok);
        tick();
        find_digit(4'b0111, found);
        n_checks++; if (found !== 1'b1 || seg_n_lz !== S3) $display("FAIL lz_nonzero: got an_n %b seg %b want 0111 %b", an_n, seg_n_lz, S3); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_midchange();
        test_reset_mid();
        test_lz_blank();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion (%0d/%0d)", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cronometro_display.md
CRONOMETRO_DISPLAY -- requirements
Module: cronometro_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per displayed digit, legal range 2 to 65535.
REQ-002 SHALL have parameter LZ_BLANK, default 0: when 1, the seconds-tens digit is blanked while it is 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cent_seg, input, 7 bits: binary hundredths count from the stopwatch, nominal range 0-99.
REQ-006 SHALL have port seg, input, 6 bits: binary seconds count from the stopwatch, nominal range 0-59.
REQ-007 SHALL have port seg_n, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port an_n, output, 4 bits: digit enables, active-low one-hot, registered.
REQ-009 SHALL have port dp_n, output, 1 bit: decimal point, active-low, registered.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse when the digit register commits a new value.

Function
REQ-011 Converter FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-012 IDLE SHALL last 1 cycle, latch cent_seg and seg into the work registers, then go to SHIFT.
REQ-013 SHIFT SHALL run 7 cycles of double-dabble on both values in parallel (seg zero-extended to 7 bits), then go to COMMIT.
REQ-014 COMMIT SHALL last 1 cycle, write the four BCD digits to the digit register atomically, assert upd for that cycle, then go to IDLE.
REQ-015 Sample-to-commit timing SHALL be fixed: inputs latched in cycle N are committed in cycle N+8; the conversion period is 9 cycles.
REQ-016 The digit register SHALL change only in COMMIT, so no torn mix of old and new digits is ever displayed.
REQ-017 A latched cent_seg > 99 SHALL commit dash codes to digits 0 and 1; a latched seg > 59 SHALL commit dash codes to digits 2 and 3. Each pair is checked independently.
REQ-018 Digit index mapping SHALL be: 0 = hundredths units, 1 = hundredths tens, 2 = seconds units, 3 = seconds tens.
REQ-019 Prescaler SHALL count 0 to SCAN_DIV-1 and wrap; on its terminal count the digit index SHALL advance 0→1→2→3→0.
REQ-020 Output register SHALL each cycle load: an_n with bit[idx]=0 and all others 1; seg_n with the decoded digit[idx]; dp_n=0 only when idx==2.
REQ-021 Outputs SHALL lag an index change by exactly 1 cycle.
REQ-022 Segment codes SHALL be: '0'=1000000, '3'=0110000, '5'=0010010, '9'=0010000, dash=0111111, blank=1111111.
REQ-023 When LZ_BLANK=1 and digit 3 holds BCD 0, seg_n SHALL be blank while idx==3; an_n and the scan sequence are unchanged.
REQ-024 Input changes during SHIFT or COMMIT SHALL be ignored until the next IDLE.

Reset
REQ-025 While reset=1 the block SHALL hold: FSM=IDLE, prescaler=0, idx=0, digit register=0000, upd=0, an_n=1111, seg_n=1111111, dp_n=1.
REQ-026 In the first cycle after reset deasserts, the outputs SHALL be an_n=1110, seg_n='0', dp_n=1.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion, with no commit and no upd pulse.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 Shared package cronometro_pkg SHALL hold: the FSM state enum, the 2-bit digit index type, the 4-bit BCD type, and the segment constants SEG_DASH and SEG_BLANK.
REQ-030 BCD-to-segment decoding SHALL be one combinational sub-module, bcd_to_7seg (4-bit input, 7-bit active-low output).
REQ-031 Prescaler width SHALL be $clog2(SCAN_DIV).

Verification (run with SCAN_DIV=4 unless noted)
REQ-032 Reset release with inputs 0/0 -> an_n=1110 and seg_n=1000000 on the first cycle; upd first pulses 9 cycles after release.
REQ-033 cent_seg=59, seg=35 held -> after upd, scan shows '9','5','5','3' on an_n=1110, 1101, 1011, 0111; dp_n=0 only with 1011.
REQ-034 cent_seg=100, seg=7 -> digits 0 and 1 show 0111111; digits 2 and 3 show '7' and '0'.
REQ-035 Inputs change during SHIFT cycle 3 -> the next commit reflects the old values; the commit after that reflects the new values.
REQ-036 Reset pulsed 1 cycle during SHIFT while digits show 59/35 -> no upd pulse, digits read 0000, and the next upd comes 9 cycles after release.
REQ-037 LZ_BLANK=1, seg=5 -> idx 3 drives seg_n=1111111 with an_n=0111; LZ_BLANK=0 -> idx 3 drives seg_n=1000000.
